stream_max_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one AXI-Stream max-finder datapath between NUM_REQ upstream streams. It grants one requester at a time, holds the grant from the first beat through TLAST, and forwards that packet to the max finder. It records the granted requester ID in an in-order FIFO so the max finder's per-packet result is routed back to the requester that sent the packet.

---
 rtl/stream_max_arbiter_if.sv | 51 +++++
 rtl/stream_max_arbiter.sv | 140 ++++++++++++++
 tb/tb_stream_max_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_max_arbiter_if.sv
// Bundle of requester streams, max-finder stream, and result routing
// signals shared between the arbiter and its environment.
interface stream_max_arbiter_if #(
   parameter int unsigned STREAM_WIDTH = 32,
   parameter int unsigned NUM_REQ      = 4
);
   localparam int unsigned IdW = $clog2(NUM_REQ);

   logic [NUM_REQ*STREAM_WIDTH-1:0] s_tdata;
   logic [NUM_REQ-1:0]              s_tvalid;
   logic [NUM_REQ-1:0]              s_tlast;
   logic [NUM_REQ-1:0]              s_tready;

   logic [STREAM_WIDTH-1:0]         m_tdata;
   logic                            m_tvalid;
   logic                            m_tlast;
   logic                            m_tready;

   logic [STREAM_WIDTH-1:0]         r_max;
   logic                            r_valid;
   logic                            r_ready;

   logic [STREAM_WIDTH-1:0]         o_max;
   logic [NUM_REQ-1:0]              o_valid;
   logic [IdW-1:0]                  o_id;
   logic                            o_ready;

   // Arbiter side.
   modport slave (
      input  s_tdata, s_tvalid, s_tlast,
      output s_tready,
      output m_tdata, m_tvalid, m_tlast,
      input  m_tready,
      input  r_max, r_valid,
      output r_ready,
      output o_max, o_valid, o_id,
      input  o_ready
   );

   // Environment side (requesters, max finder, result consumer).
   modport master (
      output s_tdata, s_tvalid, s_tlast,
      input  s_tready,
      input  m_tdata, m_tvalid, m_tlast,
      output m_tready,
      output r_max, r_valid,
      input  r_ready,
      input  o_max, o_valid, o_id,
      output o_ready
   );
endinterface

// File: rtl/stream_max_arbiter.sv
// Packet-level round-robin arbiter in front of a shared max-finder stream;
// granted IDs queue in order so each per-packet result returns to its owner.
module stream_max_arbiter #(
   parameter int unsigned STREAM_WIDTH = 32,
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned ID_DEPTH     = 4
) (
   input  logic                 ACLK,
   input  logic                 ARESET,
   stream_max_arbiter_if.slave  bus,
   output logic                 busy,
   output logic                 err_orphan
);
   localparam int unsigned IdW  = $clog2(NUM_REQ);
   localparam int unsigned PtrW = $clog2(ID_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic {StIdle, StStream} state_e;

   state_e          state_q;
   logic [IdW-1:0]  gnt_q;
   logic [IdW-1:0]  last_q;
   logic [IdW-1:0]  id_mem [ID_DEPTH];
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [CntW-1:0] count_q;

   logic [IdW-1:0]  win;
   logic            win_found;
   int unsigned     idx;
   logic            empty;
   logic            full;
   logic            push;
   logic            pop;
   logic            end_of_pkt;
   logic [IdW-1:0]  head;

   assign empty = (count_q == '0);
   assign full  = (count_q == CntW'(ID_DEPTH));
   assign head  = id_mem[rd_ptr_q];

   // Round-robin search starting just after the last requester served.
   always_comb begin
      win       = last_q;
      win_found = 1'b0;
      idx       = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (32'(last_q) + k) % NUM_REQ;
         if (!win_found && bus.s_tvalid[idx]) begin
            win       = IdW'(idx);
            win_found = 1'b1;
         end
      end
   end

   // Registered count only: a same-cycle pop never frees a slot for this grant.
   assign push       = (state_q == StIdle) && win_found && !full;
   assign pop        = bus.r_valid && bus.r_ready;
   assign end_of_pkt = (state_q == StStream) && bus.m_tvalid && bus.m_tready && bus.m_tlast;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         last_q  <= IdW'(NUM_REQ - 1);
         busy    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (push) begin
                  gnt_q   <= win;
                  state_q <= StStream;
                  busy    <= 1'b1;
               end
            end
            StStream: begin
               if (end_of_pkt) begin
                  last_q  <= gnt_q;
                  state_q <= StIdle;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (push) id_mem[wr_ptr_q] <= win;
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         err_orphan <= 1'b0;
      end else if (bus.r_valid && empty) begin
         err_orphan <= 1'b1;
      end
   end

   always_comb begin
      bus.s_tready = '0;
      bus.m_tdata  = '0;
      bus.m_tvalid = 1'b0;
      bus.m_tlast  = 1'b0;
      if (state_q == StStream) begin
         bus.m_tdata         = bus.s_tdata[32'(gnt_q)*STREAM_WIDTH +: STREAM_WIDTH];
         bus.m_tvalid        = bus.s_tvalid[gnt_q];
         bus.m_tlast         = bus.s_tlast[gnt_q];
         bus.s_tready[gnt_q] = bus.m_tready;
      end
   end

   // Head entry is meaningless while empty, so the routed ID is forced to zero.
   always_comb begin
      bus.r_ready = bus.o_ready && !empty;
      bus.o_max   = bus.r_max;
      bus.o_id    = empty ? '0 : head;
      bus.o_valid = '0;
      if (bus.r_valid && !empty) bus.o_valid = NUM_REQ'(1) << head;
   end
endmodule

// File: tb/tb_stream_max_arbiter.sv
// Directed bench for stream_max_arbiter: cycle table for the main flows plus
// hand sequences for stall, FIFO full, orphan result and asynchronous reset.
module tb_stream_max_arbiter;
   localparam int unsigned W = 32;
   localparam int unsigned N = 4;
   localparam int unsigned D = 4;

   logic ACLK;
   logic ARESET;
   logic busy;
   logic err_orphan;

   int checks = 0;
   int errors = 0;

   stream_max_arbiter_if #(.STREAM_WIDTH(W), .NUM_REQ(N)) bus ();

   stream_max_arbiter #(.STREAM_WIDTH(W), .NUM_REQ(N), .ID_DEPTH(D)) dut (
      .ACLK       (ACLK),
      .ARESET     (ARESET),
      .bus        (bus.slave),
      .busy       (busy),
      .err_orphan (err_orphan)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   typedef struct {
      bit          rst;
      logic [3:0]  tv;
      logic [3:0]  tl;
      logic [127:0] td;
      logic        mr;
      logic        rv;
      logic [31:0] rmax;
      logic [3:0]  e_str;
      logic        e_mv;
      logic        e_ml;
      logic [31:0] e_md;
      logic        e_busy;
      logic [3:0]  e_ov;
      logic [1:0]  e_id;
      logic        e_rr;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input bit rst, input logic [3:0] tv, input logic [3:0] tl,
                               input logic [127:0] td, input logic mr, input logic rv,
                               input logic [31:0] rmax, input logic [3:0] e_str,
                               input logic e_mv, input logic e_ml, input logic [31:0] e_md,
                               input logic e_busy, input logic [3:0] e_ov,
                               input logic [1:0] e_id, input logic e_rr);
      vec_t v;
      v.rst = rst; v.tv = tv; v.tl = tl; v.td = td; v.mr = mr; v.rv = rv; v.rmax = rmax;
      v.e_str = e_str; v.e_mv = e_mv; v.e_ml = e_ml; v.e_md = e_md; v.e_busy = e_busy;
      v.e_ov = e_ov; v.e_id = e_id; v.e_rr = e_rr;
      vecs.push_back(v);
   endfunction

   // Requester 0 data only.
   function automatic logic [127:0] t1(input logic [31:0] x);
      return {96'h0, x};
   endfunction

   // Requester i shows (i+1)*16+1 on beat 1 and (i+1)*16+2 on its TLAST beat.
   function automatic logic [127:0] d2(input logic [3:0] tl);
      logic [127:0] d;
      for (int i = 0; i < 4; i++) d[i*32 +: 32] = 32'((i + 1) * 16 + (tl[i] ? 2 : 1));
      return d;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.s_tdata  = '0;
      bus.s_tvalid = '0;
      bus.s_tlast  = '0;
      bus.m_tready = 1'b1;
      bus.r_max    = '0;
      bus.r_valid  = 1'b0;
      bus.o_ready  = 1'b1;
   endtask

   // Leaves the bench at posedge+1 with reset released.
   task automatic do_reset();
      ARESET = 1'b1;
      clear_inputs();
      repeat (2) @(posedge ACLK);
      #1;
      ARESET = 1'b0;
   endtask

   task automatic adv();
      @(posedge ACLK);
      #1;
   endtask

   initial begin
      ARESET = 1'b0;
      clear_inputs();
      do_reset();

      // Reset state.
      #4;
      chk("rst_s_tready", 32'(bus.s_tready), 0);
      chk("rst_m_tvalid", 32'(bus.m_tvalid), 0);
      chk("rst_m_tdata", bus.m_tdata, 0);
      chk("rst_o_valid", 32'(bus.o_valid), 0);
      chk("rst_r_ready", 32'(bus.r_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err_orphan), 0);
      adv();

      // Single 3-beat packet from requester 0, then its result.
      add(0, 4'b0001, 4'b0000, t1(10),  1, 0, 0,   4'b0000, 0, 0, 0,   0, 4'b0000, 0, 0);
      add(0, 4'b0001, 4'b0000, t1(10),  1, 0, 0,   4'b0001, 1, 0, 10,  1, 4'b0000, 0, 1);
      add(0, 4'b0001, 4'b0000, t1(500), 1, 0, 0,   4'b0001, 1, 0, 500, 1, 4'b0000, 0, 1);
      add(0, 4'b0001, 4'b0001, t1(7),   1, 0, 0,   4'b0001, 1, 1, 7,   1, 4'b0000, 0, 1);
      add(0, 4'b0000, 4'b0000, t1(0),   1, 1, 500, 4'b0000, 0, 0, 0,   0, 4'b0001, 0, 1);
      add(0, 4'b0000, 4'b0000, t1(0),   1, 0, 0,   4'b0000, 0, 0, 0,   0, 4'b0000, 0, 0);
      // All four requesters busy: grants 0,1,2,3,0 with results 11,22,33,44.
      add(1, 4'hf, 4'b0000, d2(4'b0000), 1, 0, 0,  4'b0000, 0, 0, 0,     0, 4'b0000, 0, 0);
      add(0, 4'hf, 4'b0000, d2(4'b0000), 1, 0, 0,  4'b0001, 1, 0, 'h11, 1, 4'b0000, 0, 1);
      add(0, 4'hf, 4'b0001, d2(4'b0001), 1, 0, 0,  4'b0001, 1, 1, 'h12, 1, 4'b0000, 0, 1);
      add(0, 4'hf, 4'b0000, d2(4'b0000), 1, 0, 0,  4'b0000, 0, 0, 0,     0, 4'b0000, 0, 1);
      add(0, 4'hf, 4'b0000, d2(4'b0000), 1, 1, 11, 4'b0010, 1, 0, 'h21, 1, 4'b0001, 0, 1);
      add(0, 4'hf, 4'b0010, d2(4'b0010), 1, 0, 0,  4'b0010, 1, 1, 'h22, 1, 4'b0000, 1, 1);
      add(0, 4'hf, 4'b0000, d2(4'b0000), 1, 0, 0,  4'b0000, 0, 0, 0,     0, 4'b0000, 1, 1);
      add(0, 4'hf, 4'b0000, d2(4'b0000), 1, 1, 22, 4'b0100, 1, 0, 'h31, 1, 4'b0010, 1, 1);
      add(0, 4'hf, 4'b0100, d2(4'b0100), 1, 0, 0,  4'b0100, 1, 1, 'h32, 1, 4'b0000, 2, 1);
      add(0, 4'hf, 4'b0000, d2(4'b0000), 1, 0, 0,  4'b0000, 0, 0, 0,     0, 4'b0000, 2, 1);
      add(0, 4'hf, 4'b0000, d2(4'b0000), 1, 1, 33, 4'b1000, 1, 0, 'h41, 1, 4'b0100, 2, 1);
      add(0, 4'hf, 4'b1000, d2(4'b1000), 1, 0, 0,  4'b1000, 1, 1, 'h42, 1, 4'b0000, 3, 1);
      add(0, 4'hf, 4'b0000, d2(4'b0000), 1, 0, 0,  4'b0000, 0, 0, 0,     0, 4'b0000, 3, 1);
      add(0, 4'hf, 4'b0000, d2(4'b0000), 1, 1, 44, 4'b0001, 1, 0, 'h11, 1, 4'b1000, 3, 1);
      add(0, 4'hf, 4'b0001, d2(4'b0001), 1, 0, 0,  4'b0001, 1, 1, 'h12, 1, 4'b0000, 0, 1);

      foreach (vecs[k]) begin
         if (vecs[k].rst) do_reset();
         bus.s_tvalid = vecs[k].tv;
         bus.s_tlast  = vecs[k].tl;
         bus.s_tdata  = vecs[k].td;
         bus.m_tready = vecs[k].mr;
         bus.r_valid  = vecs[k].rv;
         bus.r_max    = vecs[k].rmax;
         #4;
         checks++;
         if ({bus.s_tready, bus.m_tvalid, bus.m_tlast, bus.m_tdata, busy, bus.o_valid,
              bus.o_id, bus.r_ready, bus.o_max} !==
             {vecs[k].e_str, vecs[k].e_mv, vecs[k].e_ml, vecs[k].e_md, vecs[k].e_busy,
              vecs[k].e_ov, vecs[k].e_id, vecs[k].e_rr, vecs[k].rmax}) begin
            errors++;
            $display("FAIL row%0d actual str=%b mv=%b ml=%b md=%0h busy=%b ov=%b id=%0d rr=%b max=%0d required str=%b mv=%b ml=%b md=%0h busy=%b ov=%b id=%0d rr=%b max=%0d",
                     k, bus.s_tready, bus.m_tvalid, bus.m_tlast, bus.m_tdata, busy,
                     bus.o_valid, bus.o_id, bus.r_ready, bus.o_max, vecs[k].e_str,
                     vecs[k].e_mv, vecs[k].e_ml, vecs[k].e_md, vecs[k].e_busy, vecs[k].e_ov,
                     vecs[k].e_id, vecs[k].e_rr, vecs[k].rmax);
         end
         adv();
      end

      // Requester 2 stalled by m_tready while requester 1 waits.
      do_reset();
      bus.s_tvalid = 4'b0100;
      bus.s_tdata  = {32'h0, 32'haaaa, 32'h0, 32'h0};
      #4; chk("stall_idle_busy", 32'(busy), 0);
      adv();
      bus.s_tvalid = 4'b0110;
      bus.s_tdata  = {32'h0, 32'haaaa, 32'h1111, 32'h0};
      #4; chk("stall_gnt2", 32'(bus.s_tready), 32'b0100);
      chk("stall_data_a", bus.m_tdata, 32'haaaa);
      adv();
      bus.m_tready = 1'b0;
      bus.s_tdata  = {32'h0, 32'hbbbb, 32'h1111, 32'h0};
      #4; chk("stall_tready0", 32'(bus.s_tready), 0);
      chk("stall_data_b", bus.m_tdata, 32'hbbbb);
      adv();
      #4; chk("stall_hold_data", bus.m_tdata, 32'hbbbb);
      chk("stall_hold_valid", 32'(bus.m_tvalid), 1);
      adv();
      bus.m_tready = 1'b1;
      bus.s_tlast  = 4'b0100;
      #4; chk("stall_last_ready", 32'(bus.s_tready), 32'b0100);
      chk("stall_last", 32'(bus.m_tlast), 1);
      adv();
      bus.s_tvalid = 4'b0010;
      bus.s_tlast  = 4'b0000;
      #4; chk("stall_gap_busy", 32'(busy), 0);
      adv();
      #4; chk("stall_next_gnt1", 32'(bus.s_tready), 32'b0010);
      adv();

      // Four single-beat packets fill the ID FIFO; a pop does not bypass.
      do_reset();
      bus.s_tvalid = 4'b0001;
      bus.s_tlast  = 4'b0001;
      bus.s_tdata  = t1(5);
      repeat (8) @(posedge ACLK);
      #1;
      #4; chk("full_no_grant", 32'(busy), 0);
      chk("full_r_ready", 32'(bus.r_ready), 1);
      adv();
      bus.r_valid = 1'b1;
      bus.r_max   = 32'd99;
      #4; chk("full_still_idle", 32'(bus.s_tready), 0);
      chk("full_pop_ov", 32'(bus.o_valid), 32'b0001);
      adv();
      bus.r_valid = 1'b0;
      #4; chk("full_no_bypass", 32'(busy), 0);
      adv();
      #4; chk("full_regrant_busy", 32'(busy), 1);
      chk("full_regrant_rdy", 32'(bus.s_tready), 32'b0001);
      adv();

      // Result with nothing outstanding.
      do_reset();
      bus.r_valid = 1'b1;
      bus.r_max   = 32'd77;
      #4; chk("orph_r_ready", 32'(bus.r_ready), 0);
      chk("orph_o_valid", 32'(bus.o_valid), 0);
      chk("orph_err_pre", 32'(err_orphan), 0);
      adv();
      bus.r_valid = 1'b0;
      #4; chk("orph_err_set", 32'(err_orphan), 1);
      adv();
      #4; chk("orph_err_hold", 32'(err_orphan), 1);
      #1; ARESET = 1'b1;
      #1; chk("orph_err_clr", 32'(err_orphan), 0);
      ARESET = 1'b0;
      adv();

      // Asynchronous reset during beat 2 of a 5-beat packet.
      do_reset();
      bus.s_tvalid = 4'b0011;
      bus.s_tdata  = {32'h0, 32'h0, 32'h2222, 32'h5050};
      adv();
      adv();
      #2; chk("ar_pre_ready", 32'(bus.s_tready), 32'b0001);
      ARESET = 1'b1;
      #1; chk("ar_tready", 32'(bus.s_tready), 0);
      chk("ar_tvalid", 32'(bus.m_tvalid), 0);
      chk("ar_busy", 32'(busy), 0);
      @(posedge ACLK);
      #1;
      ARESET = 1'b0;
      #4; chk("ar_fifo_empty", 32'(bus.r_ready), 0);
      adv();
      #4; chk("ar_req0_first", 32'(bus.s_tready), 32'b0001);
      chk("ar_data", bus.m_tdata, 32'h5050);
      adv();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
